hazard_unit: RTL and testbench

- Central pipeline hazard controller for the 5-stage MIPS core; the producer of the stall*/flush* inputs that the pipeline control registers consume.
- Detects load-use and branch-operand RAW hazards, generates forwarding selects, and sequences multi-cycle divide stalls and data-memory wait stalls through a small FSM.
- Sits beside the datapath; all outputs go to the pipeline register enables and clears and to the operand forwarding muxes.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/forward_unit.sv | 42 ++++
 rtl/hazard_unit.sv | 176 +++++++++++++++++
 tb/tb_hazard_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding selects,
// divide-sequencer state encoding and the hard-wired zero register.
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE     = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_e;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic reg_hit(input logic       wr_en,
                                     input logic [4:0] dst,
                                     input logic [4:0] src);
        return wr_en && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select generation for the Execute ALU inputs and the
// Decode-stage branch comparator. Purely combinational.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rsD_i,
    input  logic [4:0] rtD_i,
    input  logic [4:0] rsE_i,
    input  logic [4:0] rtE_i,
    input  logic [4:0] writeregM_i,
    input  logic [4:0] writeregW_i,
    input  logic       regwriteM_i,
    input  logic       regwriteW_i,
    output logic       forwardAD_o,
    output logic       forwardBD_o,
    output logic [1:0] forwardAE_o,
    output logic [1:0] forwardBE_o
);

    // The younger producer in M shadows an older write to the same register in W.
    always_comb begin
        forwardAE_o = FWD_NONE;
        if (reg_hit(regwriteM_i, writeregM_i, rsE_i)) begin
            forwardAE_o = FWD_MEM;
        end else if (reg_hit(regwriteW_i, writeregW_i, rsE_i)) begin
            forwardAE_o = FWD_WB;
        end
    end

    always_comb begin
        forwardBE_o = FWD_NONE;
        if (reg_hit(regwriteM_i, writeregM_i, rtE_i)) begin
            forwardBE_o = FWD_MEM;
        end else if (reg_hit(regwriteW_i, writeregW_i, rtE_i)) begin
            forwardBE_o = FWD_WB;
        end
    end

    assign forwardAD_o = reg_hit(regwriteM_i, writeregM_i, rsD_i);
    assign forwardBD_o = reg_hit(regwriteM_i, writeregM_i, rtD_i);

endmodule

// File: rtl/hazard_unit.sv
// Central hazard controller: RAW stall detection, forwarding, divide and memory-wait
// stall sequencing. Define HAZARD_PERF_CNT_EN to add stall/divide cycle counters.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | no divide in flight; a div_startE here stalls E and loads cnt
//   DIV_BUSY | divide counting down; at cnt==0 waits out any memory stall,
//            | then pulses div_readyE and returns to IDLE
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 36
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  writeregE,
    input  logic [4:0]  writeregM,
    input  logic [4:0]  writeregW,
    input  logic        regwriteE,
    input  logic        regwriteM,
    input  logic        regwriteW,
    input  logic        memtoregE,
    input  logic        memtoregM,
    input  logic        branchD,
    input  logic        jrD,
    input  logic        div_startE,
    input  logic        mem_reqM,
    input  logic        mem_ackM,
    input  logic        flush_except,
    output logic        forwardAD,
    output logic        forwardBD,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        stallW,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic        div_readyE,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] div_cycles,
`endif
    output logic        div_busy
);

    localparam int              CNT_W    = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_stall, div_ready;
    logic             lwstall, brstall, mem_stall, d_uses_e, d_uses_m_load;

    forward_unit u_forward (
        .rsD_i       (rsD),
        .rtD_i       (rtD),
        .rsE_i       (rsE),
        .rtE_i       (rtE),
        .writeregM_i (writeregM),
        .writeregW_i (writeregW),
        .regwriteM_i (regwriteM),
        .regwriteW_i (regwriteW),
        .forwardAD_o (forwardAD),
        .forwardBD_o (forwardBD),
        .forwardAE_o (forwardAE),
        .forwardBE_o (forwardBE)
    );

    assign mem_stall     = mem_reqM & ~mem_ackM;
    assign lwstall       = reg_hit(memtoregE, writeregE, rsD) | reg_hit(memtoregE, writeregE, rtD);
    assign d_uses_e      = reg_hit(regwriteE, writeregE, rsD) | reg_hit(regwriteE, writeregE, rtD);
    assign d_uses_m_load = reg_hit(memtoregM, writeregM, rsD) | reg_hit(memtoregM, writeregM, rtD);
    assign brstall       = (branchD | jrD) & (d_uses_e | d_uses_m_load);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_stall = 1'b0;
        div_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (div_startE) begin
                    div_stall = 1'b1;
                    state_d   = DIV_BUSY;
                    cnt_d     = CNT_LOAD;
                end
            end
            DIV_BUSY: begin
                // The count keeps running under a memory wait; only the final release waits for it.
                if (cnt_q != '0) begin
                    div_stall = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end else if (!mem_stall) begin
                    div_ready = 1'b1;
                    state_d   = IDLE;
                end else begin
                    div_stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_except) begin
            state_d   = IDLE;
            cnt_d     = '0;
            div_stall = 1'b0;
            div_ready = 1'b0;
        end
    end

    always_comb begin
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        stallM     = 1'b0;
        stallW     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        flushM     = 1'b0;
        flushW     = 1'b0;
        div_readyE = 1'b0;
        if (rst || flush_except) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else begin
            stallW     = mem_stall;
            stallM     = mem_stall;
            stallE     = mem_stall | div_stall;
            stallD     = stallE | lwstall | brstall;
            stallF     = stallD;
            flushE     = (lwstall | brstall) & ~stallE;
            flushM     = div_stall & ~mem_stall;
            div_readyE = div_ready;
        end
    end

    assign div_busy = (state_q == DIV_BUSY);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, div_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            div_cycles_q   <= '0;
        end else begin
            if (stallF)    stall_cycles_q <= stall_cycles_q + 32'd1;
            if (div_stall) div_cycles_q   <= div_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign div_cycles   = div_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard/divide/exception scenarios
// followed by randomized hazard traffic checked against a rule-level model.
module tb_hazard_unit;

    localparam int DC = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, jrD, div_startE, mem_reqM, mem_ackM, flush_except;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, stallE, stallM, stallW;
    logic       flushD, flushE, flushM, flushW, div_readyE, div_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, div_cycles;
`endif

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    hazard_unit #(.DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jrD(jrD), .div_startE(div_startE),
        .mem_reqM(mem_reqM), .mem_ackM(mem_ackM), .flush_except(flush_except),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .div_readyE(div_readyE),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(stall_cycles), .div_cycles(div_cycles),
`endif
        .div_busy(div_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0; branchD = 0; jrD = 0;
        div_startE = 0; mem_reqM = 0; mem_ackM = 0; flush_except = 0;
    endtask

    // Inputs change 1 unit after the rising edge; outputs are sampled 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic hit(input logic we, input logic [4:0] d, input logic [4:0] s);
        return we && (d != 5'd0) && (d == s);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (hit(regwriteM, writeregM, src)) return 2'd2;
        if (hit(regwriteW, writeregW, src)) return 2'd1;
        return 2'd0;
    endfunction

    // Full output check for cycles where no divide is in flight.
    task automatic check_model(input string tag);
        logic lw, br, ms, e_stallE, e_stallD;
        lw = memtoregE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
        br = (branchD || jrD) &&
             ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
              (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
        ms = mem_reqM && !mem_ackM;
        e_stallE = flush_except ? 1'b0 : ms;
        e_stallD = flush_except ? 1'b0 : (ms || lw || br);
        chk({tag, ".fAE"}, 32'(forwardAE), 32'(fwd_sel(rsE)));
        chk({tag, ".fBE"}, 32'(forwardBE), 32'(fwd_sel(rtE)));
        chk({tag, ".fAD"}, 32'(forwardAD), 32'(hit(regwriteM, writeregM, rsD)));
        chk({tag, ".fBD"}, 32'(forwardBD), 32'(hit(regwriteM, writeregM, rtD)));
        chk({tag, ".stallF"}, 32'(stallF), 32'(e_stallD));
        chk({tag, ".stallD"}, 32'(stallD), 32'(e_stallD));
        chk({tag, ".stallE"}, 32'(stallE), 32'(e_stallE));
        chk({tag, ".stallM"}, 32'(stallM), 32'(e_stallE));
        chk({tag, ".stallW"}, 32'(stallW), 32'(e_stallE));
        chk({tag, ".flushD"}, 32'(flushD), 32'(flush_except));
        chk({tag, ".flushE"}, 32'(flushE), 32'(flush_except ? 1'b1 : ((lw || br) && !e_stallE)));
        chk({tag, ".flushM"}, 32'(flushM), 32'(flush_except));
        chk({tag, ".flushW"}, 32'(flushW), 32'(flush_except));
        chk({tag, ".ready"}, 32'(div_readyE), 32'(0));
        chk({tag, ".busy"}, 32'(div_busy), 32'(0));
    endtask

    // Divide started in cycle 0 and held until released; memory wait over [lo,hi];
    // an exception at cycle exc (negative = none) aborts the divide.
    task automatic run_div(input string tag, input int lo, input int hi, input int exc);
        int  rc, last;
        logic ms, dstall;
        rc = DC;
        while (rc >= lo && rc <= hi) rc++;
        last = (exc >= 0) ? exc + 1 : rc + 1;
        for (int c = 0; c <= last; c++) begin
            next_cycle();
            clear_inputs();
            ms = (c >= lo && c <= hi);
            mem_reqM     = ms;
            div_startE   = (exc >= 0) ? (c <= exc) : (c <= rc);
            flush_except = (c == exc);
            #2;
            if (c == exc) begin
                chk({tag, ".exc_stallF"}, 32'(stallF), 32'(0));
                chk({tag, ".exc_stallE"}, 32'(stallE), 32'(0));
                chk({tag, ".exc_stallW"}, 32'(stallW), 32'(0));
                chk({tag, ".exc_flushD"}, 32'(flushD), 32'(1));
                chk({tag, ".exc_flushE"}, 32'(flushE), 32'(1));
                chk({tag, ".exc_flushM"}, 32'(flushM), 32'(1));
                chk({tag, ".exc_flushW"}, 32'(flushW), 32'(1));
                chk({tag, ".exc_ready"}, 32'(div_readyE), 32'(0));
                chk({tag, ".exc_busy"}, 32'(div_busy), 32'(1));
            end else if (exc >= 0 && c > exc) begin
                chk({tag, ".post_busy"}, 32'(div_busy), 32'(0));
                chk({tag, ".post_ready"}, 32'(div_readyE), 32'(0));
                chk({tag, ".post_stallE"}, 32'(stallE), 32'(ms));
            end else begin
                dstall = (c < rc);
                chk($sformatf("%s.c%0d.stallE", tag, c), 32'(stallE), 32'(dstall || ms));
                chk($sformatf("%s.c%0d.stallD", tag, c), 32'(stallD), 32'(dstall || ms));
                chk($sformatf("%s.c%0d.stallM", tag, c), 32'(stallM), 32'(ms));
                chk($sformatf("%s.c%0d.flushM", tag, c), 32'(flushM), 32'(dstall && !ms));
                chk($sformatf("%s.c%0d.ready", tag, c), 32'(div_readyE), 32'(c == rc));
                chk($sformatf("%s.c%0d.busy", tag, c), 32'(div_busy), 32'(c >= 1 && c <= rc));
            end
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        regwriteM = 1; writeregM = 5; rsE = 5;
        #3;
        chk("rst.stallF", 32'(stallF), 32'(0));
        chk("rst.stallE", 32'(stallE), 32'(0));
        chk("rst.stallW", 32'(stallW), 32'(0));
        chk("rst.flushD", 32'(flushD), 32'(1));
        chk("rst.flushE", 32'(flushE), 32'(1));
        chk("rst.flushM", 32'(flushM), 32'(1));
        chk("rst.flushW", 32'(flushW), 32'(1));
        chk("rst.ready",  32'(div_readyE), 32'(0));
        chk("rst.busy",   32'(div_busy), 32'(0));
        chk("rst.fAE",    32'(forwardAE), 32'(2));
        next_cycle();
        rst = 1'b0;
        clear_inputs();

        // Load-use then forward from M on the following cycle.
        next_cycle();
        clear_inputs();
        memtoregE = 1; regwriteE = 1; writeregE = 8; rsD = 8;
        #2;
        chk("lu.stallF", 32'(stallF), 32'(1));
        chk("lu.stallD", 32'(stallD), 32'(1));
        chk("lu.flushE", 32'(flushE), 32'(1));
        chk("lu.stallE", 32'(stallE), 32'(0));
        next_cycle();
        clear_inputs();
        memtoregM = 1; regwriteM = 1; writeregM = 8; rsE = 8;
        #2;
        chk("lu.fwd", 32'(forwardAE), 32'(2));
        chk("lu.stallD2", 32'(stallD), 32'(0));
        chk("lu.flushE2", 32'(flushE), 32'(0));

        // Forward priority and zero register.
        next_cycle();
        clear_inputs();
        regwriteM = 1; regwriteW = 1; writeregM = 5; writeregW = 5; rsE = 5; rtE = 5;
        #2;
        chk("prio.fAE", 32'(forwardAE), 32'(2));
        chk("prio.fBE", 32'(forwardBE), 32'(2));
        writeregM = 0;
        #1;
        chk("zero.fAE", 32'(forwardAE), 32'(1));
        chk("zero.fBE", 32'(forwardBE), 32'(1));

        // Branch operand hazard, then the same against r0.
        next_cycle();
        clear_inputs();
        branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
        #2;
        chk("br.stallD", 32'(stallD), 32'(1));
        chk("br.flushE", 32'(flushE), 32'(1));
        writeregE = 0;
        #1;
        chk("br0.stallD", 32'(stallD), 32'(0));
        chk("br0.flushE", 32'(flushE), 32'(0));

        run_div("div", 100, 99, -1);
        run_div("div_early_mem", 2, 6, -1);
        run_div("div_late_mem", DC - 2, DC + 2, -1);
        run_div("div_exc", 100, 99, 10);

        // Asynchronous reset in the middle of a divide.
        next_cycle();
        clear_inputs();
        div_startE = 1;
        repeat (3) next_cycle();
        #2;
        chk("arst.pre_busy", 32'(div_busy), 32'(1));
        rst = 1'b1;
        #1;
        chk("arst.busy",   32'(div_busy), 32'(0));
        chk("arst.stallE", 32'(stallE), 32'(0));
        chk("arst.flushM", 32'(flushM), 32'(1));
        next_cycle();
        rst = 1'b0;
        div_startE = 0;
        #2;
        chk("arst.after_busy", 32'(div_busy), 32'(0));
        chk("arst.after_stallE", 32'(stallE), 32'(0));

        // Randomized hazard traffic with no divide in flight.
        for (int i = 0; i < 250; i++) begin
            next_cycle();
            clear_inputs();
            rsD = 5'($urandom_range(0, 7)); rtD = 5'($urandom_range(0, 7));
            rsE = 5'($urandom_range(0, 7)); rtE = 5'($urandom_range(0, 7));
            writeregE = 5'($urandom_range(0, 7));
            writeregM = 5'($urandom_range(0, 7));
            writeregW = 5'($urandom_range(0, 7));
            regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
            memtoregE = 1'($urandom); memtoregM = 1'($urandom);
            branchD = 1'($urandom); jrD = ($urandom_range(0, 3) == 0);
            mem_reqM = 1'($urandom); mem_ackM = 1'($urandom);
            flush_except = ($urandom_range(0, 15) == 0);
            #2;
            check_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
